// File: rtl/dmem_port_arbiter.sv
// Shares SRAM port 0 of the data memory between the core data port and the Wishbone slave.
// The core normally wins; Wishbone wins under processor_reset or after STARVE_MAX lost cycles.
module dmem_port_arbiter #(
    parameter int          ADDR_W     = 8,
    parameter logic [31:0] WB_BASE    = 32'h3000_1000,
    parameter int          STARVE_MAX = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              processor_reset,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [3:0]        core_wmask,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [31:0]       core_rdata,
    output logic              sram_csb0,
    output logic              sram_web0,
    output logic [3:0]        sram_wmask0,
    output logic [ADDR_W-1:0] sram_addr0,
    output logic [31:0]       sram_din0,
    input  logic [31:0]       sram_dout0
);

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_WAIT = 2'd1,
        WB_RESP = 2'd2
    } wb_state_t;

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

    wb_state_t          wb_state_r;
    logic [SW-1:0]      starve_cnt_r;
    logic               wb_ack_r;
    logic               core_rvalid_r;
    logic [ADDR_W-1:0]  addr_hold_r;
    logic [31:0]        din_hold_r;

    logic               wb_hit_s;
    logic               wb_pending_s;
    logic               wb_forced_s;
    logic               wb_gnt_s;
    logic               core_gnt_s;
    logic [ADDR_W-1:0]  wb_word_s;
    logic               unused_s;

    assign unused_s     = ^wbs_adr_i[1:0];
    assign wb_hit_s     = wbs_cyc_i & wbs_stb_i &
                          (wbs_adr_i[31:ADDR_W+2] == WB_BASE[31:ADDR_W+2]);
    assign wb_word_s    = wbs_adr_i[ADDR_W+1:2];
    // A request dropped by the master while waiting simply falls back to idle.
    assign wb_pending_s = ((wb_state_r == WB_IDLE) || (wb_state_r == WB_WAIT)) & wb_hit_s;
    assign wb_forced_s  = processor_reset | (starve_cnt_r == STARVE_LIM);
    assign wb_gnt_s     = ~wb_rst_i & wb_pending_s & (wb_forced_s | ~core_req);
    assign core_gnt_s   = ~wb_rst_i & core_req & ~wb_gnt_s;

    assign core_gnt     = core_gnt_s;
    assign core_rvalid  = core_rvalid_r;
    assign core_rdata   = core_rvalid_r ? sram_dout0 : 32'h0000_0000;
    assign wbs_ack_o    = wb_ack_r;
    assign wbs_dat_o    = wb_ack_r ? sram_dout0 : 32'h0000_0000;

    // SRAM port drive for the winner of this cycle; addr/din park on the last access.
    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = 4'h0;
        sram_addr0  = addr_hold_r;
        sram_din0   = din_hold_r;
        if (core_gnt_s) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~core_we;
            sram_wmask0 = core_wmask;
            sram_addr0  = core_addr;
            sram_din0   = core_wdata;
        end else if (wb_gnt_s) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~wbs_we_i;
            sram_wmask0 = wbs_sel_i;
            sram_addr0  = wb_word_s;
            sram_din0   = wbs_dat_i;
        end else begin
            sram_csb0   = 1'b1;
        end
    end

    // Wishbone FSM, starvation counter, response flags and parked SRAM fields.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_state_r    <= WB_IDLE;
            starve_cnt_r  <= '0;
            wb_ack_r      <= 1'b0;
            core_rvalid_r <= 1'b0;
            addr_hold_r   <= '0;
            din_hold_r    <= 32'h0000_0000;
        end else begin
            wb_ack_r      <= wb_gnt_s;
            core_rvalid_r <= core_gnt_s & ~core_we;
            if (core_gnt_s || wb_gnt_s) begin
                addr_hold_r <= sram_addr0;
                din_hold_r  <= sram_din0;
            end
            // The losing cycle in IDLE counts too, so a WB hit waits at most STARVE_MAX cycles.
            if (wb_gnt_s || !wb_pending_s) begin
                starve_cnt_r <= '0;
            end else if (starve_cnt_r != STARVE_LIM) begin
                starve_cnt_r <= starve_cnt_r + SW'(1);
            end
            case (wb_state_r)
                WB_IDLE, WB_WAIT: begin
                    if (wb_gnt_s) begin
                        wb_state_r <= WB_RESP;
                    end else if (wb_pending_s) begin
                        wb_state_r <= WB_WAIT;
                    end else begin
                        wb_state_r <= WB_IDLE;
                    end
                end
                WB_RESP: wb_state_r <= WB_IDLE;
                default: wb_state_r <= WB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural SRAM and a read-data scoreboard.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        processor_reset;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        core_req, core_we;
    logic [3:0]  core_wmask;
    logic [7:0]  core_addr;
    logic [31:0] core_wdata;
    logic        core_gnt, core_rvalid;
    logic [31:0] core_rdata;
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0;

    logic [31:0] sram_mem [256];
    logic [31:0] ref_mem  [256];
    logic [31:0] core_q [$];
    logic [31:0] wb_q [$];
    logic        wb_rd;
    int          checks = 0;
    int          errors = 0;

    dmem_port_arbiter dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .processor_reset(processor_reset),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .core_req(core_req), .core_we(core_we), .core_wmask(core_wmask),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = 32'h0000_0000;
            ref_mem[i]  = 32'h0000_0000;
        end
        sram_dout0 = 32'h0000_0000;
    end

    // Behavioural SRAM macro: masked write, registered read.
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask0[b]) sram_mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
            end else begin
                sram_dout0 <= sram_mem[sram_addr0];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ref_write(input logic [7:0] a, input logic [3:0] m, input logic [31:0] d);
        for (int b = 0; b < 4; b++)
            if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_drive(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = 4'hF; wbs_adr_i = adr; wbs_dat_i = dat;
        wb_rd = ~we;
        if (we) ref_write(adr[9:2], 4'hF, dat);
        else    wb_q.push_back(ref_mem[adr[9:2]]);
    endtask

    task automatic wb_drop();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wb_rd = 1'b0;
    endtask

    // Waits (bounded) for an ack, then releases the bus at the next edge.
    task automatic wb_wait_ack(input string tag, input int max_cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (wbs_ack_o) seen = 1'b1;
            next_cycle();
        end
        chk(tag, seen, 1'b1);
        wb_drop();
    endtask

    // Scoreboard: pop expected read data when the DUT presents it, push on core read grants.
    always @(negedge clk) begin
        if (core_rvalid) begin
            if (core_q.size() == 0) chk("core_rvalid_spurious", core_rvalid, 1'b0);
            else chk("core_rdata", core_rdata, core_q.pop_front());
        end
        if (wbs_ack_o && wb_rd) begin
            if (wb_q.size() == 0) chk("wb_ack_spurious", wbs_ack_o, 1'b0);
            else chk("wbs_dat_o", wbs_dat_o, wb_q.pop_front());
        end
        if (core_gnt && !core_we) core_q.push_back(ref_mem[core_addr]);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; processor_reset = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
        wbs_adr_i = 32'h0; wbs_dat_i = 32'h0; wb_rd = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_wmask = 4'h0; core_addr = 8'd0; core_wdata = 32'h0;
        next_cycle(); next_cycle();

        // Reset state, with a core request held during reset.
        @(negedge clk);
        chk("rst_core_gnt", core_gnt, 1'b0);
        chk("rst_csb0", sram_csb0, 1'b1);
        chk("rst_web0", sram_web0, 1'b1);
        chk("rst_wmask0", sram_wmask0, 4'h0);
        chk("rst_ack", wbs_ack_o, 1'b0);
        chk("rst_rvalid", core_rvalid, 1'b0);
        chk("rst_wbs_dat_o", wbs_dat_o, 32'h0);
        next_cycle();
        rst = 1'b0; core_req = 1'b0;
        next_cycle();

        // Host write then read while the core is held in reset.
        wb_drive(1'b1, 32'h3000_1010, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("pr_wr_csb0", sram_csb0, 1'b0);
        chk("pr_wr_addr0", sram_addr0, 8'd4);
        chk("pr_wr_web0", sram_web0, 1'b0);
        chk("pr_wr_din0", sram_din0, 32'hDEAD_BEEF);
        chk("pr_wr_ack_c0", wbs_ack_o, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("pr_wr_ack_c1", wbs_ack_o, 1'b1);
        next_cycle();
        wb_drive(1'b0, 32'h3000_1010, 32'h0);
        @(negedge clk);
        chk("pr_rd_csb0", sram_csb0, 1'b0);
        chk("pr_rd_web0", sram_web0, 1'b1);
        next_cycle();
        wb_wait_ack("pr_rd_ack", 2);
        wb_drive(1'b1, 32'h3000_101C, 32'hA5A5_5A5A);
        wb_wait_ack("pr_wr7_ack", 3);

        // Core streams reads of word 4; a concurrent WB read is forced in after 4 lost cycles.
        processor_reset = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'd4;
        wb_drive(1'b0, 32'h3000_1010, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("starve_gnt_c%0d", k), core_gnt, (k != 5));
            chk($sformatf("starve_csb_c%0d", k), sram_csb0, 1'b0);
            chk($sformatf("starve_ack_c%0d", k), wbs_ack_o, (k == 6));
            next_cycle();
            if (k == 6) wb_drop();
        end
        core_req = 1'b0;
        next_cycle();

        // Simultaneous core half-word write and WB read of the same word.
        core_req = 1'b1; core_we = 1'b1; core_addr = 8'd2;
        core_wmask = 4'b0011; core_wdata = 32'h0000_ABCD;
        ref_write(8'd2, 4'b0011, 32'h0000_ABCD);
        wb_drive(1'b0, 32'h3000_1008, 32'h0);
        @(negedge clk);
        chk("sim_core_gnt", core_gnt, 1'b1);
        chk("sim_core_web0", sram_web0, 1'b0);
        chk("sim_core_wmask0", sram_wmask0, 4'b0011);
        next_cycle();
        core_req = 1'b0; core_we = 1'b0; core_wmask = 4'h0;
        @(negedge clk);
        chk("sim_core_rvalid_wr", core_rvalid, 1'b0);
        chk("sim_wb_csb0", sram_csb0, 1'b0);
        chk("sim_wb_addr0", sram_addr0, 8'd2);
        next_cycle();
        wb_wait_ack("sim_wb_ack", 2);

        // Access outside the window: no SRAM activity and no ack.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_2000;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("miss_csb0", sram_csb0, 1'b1);
            chk("miss_ack", wbs_ack_o, 1'b0);
            next_cycle();
        end
        wb_drop();

        // Reset while the WB request is waiting behind the core.
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'd0;
        wb_drive(1'b0, 32'h3000_1000, 32'h0);
        @(negedge clk);
        chk("rw_core_gnt", core_gnt, 1'b1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rw_gnt_in_rst", core_gnt, 1'b0);
        chk("rw_csb_in_rst", sram_csb0, 1'b1);
        next_cycle();
        @(negedge clk);
        chk("rw_ack_after", wbs_ack_o, 1'b0);
        chk("rw_csb_after", sram_csb0, 1'b1);
        next_cycle();
        rst = 1'b0; core_req = 1'b0; wb_drop(); wb_q.delete();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rw_no_late_ack", wbs_ack_o, 1'b0);
            next_cycle();
        end

        // Single core read of the preloaded word 7.
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'd7;
        @(negedge clk);
        chk("rd7_gnt", core_gnt, 1'b1);
        next_cycle();
        core_req = 1'b0;
        @(negedge clk);
        chk("rd7_rvalid", core_rvalid, 1'b1);
        chk("rd7_rdata", core_rdata, 32'hA5A5_5A5A);
        chk("rd7_wb_ack", wbs_ack_o, 1'b0);
        chk("rd7_wb_dat", wbs_dat_o, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("rd7_rvalid_off", core_rvalid, 1'b0);
        next_cycle();

        chk("core_q_drained", core_q.size(), 32'd0);
        chk("wb_q_drained", wb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
